// File: rtl/data_mem.sv
// Handshaked byte-addressed data memory with masked/extended loads and stores, wait states,
// and automatic splitting of word-straddling accesses into two word transactions.
package data_mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } memory_mask_t;
endpackage

module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  memory_mask_t req_mask,
  input  logic         req_unsigned,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         resp_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACC_LO = 3'd2;
  localparam logic [2:0] S_ACC_HI = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Byte enables of an aligned access; an illegal mask enables nothing.
  function automatic logic [3:0] size_be(input memory_mask_t m);
    case (m)
      MEM_BYTE:     size_be = 4'b0001;
      MEM_HALFWORD: size_be = 4'b0011;
      MEM_WORD:     size_be = 4'b1111;
      default:      size_be = 4'b0000;
    endcase
  endfunction

  // pair = {word w+1, word w}; bring byte o down to bit 0, then trim and extend.
  function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                              input memory_mask_t m, input logic uns);
    logic [31:0] a;
    a = 32'(pair >> {off, 3'b000});
    case (m)
      MEM_BYTE:     extend_load = uns ? {24'd0, a[7:0]} : {{24{a[7]}}, a[7:0]};
      MEM_HALFWORD: extend_load = uns ? {16'd0, a[15:0]} : {{16{a[15]}}, a[15:0]};
      default:      extend_load = a;
    endcase
  endfunction

  logic [31:0] mem [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          we_q, we_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  memory_mask_t  mask_q, mask_d;
  logic          uns_q, uns_d;
  logic          err_q, err_d;
  logic          split_q, split_d;
  logic [31:0]   lo_word_q, lo_word_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [AW-1:0] rd_idx_d;
  logic [31:0]   rd_data_q;

  logic          accept;
  logic [7:0]    req_be8;
  logic          req_split;
  logic [31:0]   req_word;
  logic          req_err;

  logic [7:0]    be8;
  logic [63:0]   wdata64;
  logic          wr_en;
  logic          wr_hi;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Range and split are judged on the incoming request so the error is fixed at accept.
  assign req_be8   = {4'b0000, size_be(req_mask)} << req_addr[1:0];
  assign req_split = |req_be8[7:4];
  assign req_word  = {2'b00, req_addr[31:2]};
  assign req_err   = (size_be(req_mask) == 4'b0000) || (req_word >= DEPTH_W) ||
                     (req_split && ((req_word + 32'd1) >= DEPTH_W));

  assign be8     = {4'b0000, size_be(mask_q)} << off_q;
  assign wdata64 = {32'd0, wdata_q} << {off_q, 3'b000};
  assign wr_hi   = (state_q == S_ACC_HI);
  assign wr_idx  = wr_hi ? (idx_q + AW'(1)) : idx_q;
  assign wr_en   = !rst && we_q && !err_q && ((state_q == S_ACC_LO) || wr_hi);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_be[gi]         = wr_hi ? be8[gi + 4] : be8[gi];
    assign wr_word[8*gi +: 8] = wr_hi ? wdata64[32 + 8*gi +: 8] : wdata64[8*gi +: 8];
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    we_d         = we_q;
    off_d        = off_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    uns_d        = uns_q;
    err_d        = err_q;
    split_d      = split_q;
    lo_word_d    = lo_word_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    rd_idx_d     = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d       = req_we;
          off_d      = req_addr[1:0];
          idx_d      = req_addr[AW+1:2];
          wdata_d    = req_wdata;
          mask_d     = req_mask;
          uns_d      = req_unsigned;
          err_d      = req_err;
          split_d    = req_split && !req_err;
          rd_idx_d   = req_addr[AW+1:2];
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_ACC_LO;
          wait_cnt_d = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = S_ACC_LO;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      S_ACC_LO: begin
        lo_word_d = rd_data_q;
        if (split_q) begin
          state_d  = S_ACC_HI;
          rd_idx_d = idx_q + AW'(1);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = (we_q || err_q) ? 32'd0 :
                         extend_load({32'd0, rd_data_q}, off_q, mask_q, uns_q);
        end
      end
      S_ACC_HI: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (we_q || err_q) ? 32'd0 :
                       extend_load({rd_data_q, lo_word_q}, off_q, mask_q, uns_q);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      we_q         <= 1'b0;
      off_q        <= 2'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      mask_q       <= MEM_BYTE;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      split_q      <= 1'b0;
      lo_word_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      we_q         <= we_d;
      off_q        <= off_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      uns_q        <= uns_d;
      err_q        <= err_d;
      split_q      <= split_d;
      lo_word_q    <= lo_word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Read address is presented one edge early so the word is registered by ACC_LO/ACC_HI.
  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_idx_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed checks of data_mem with zero and three wait states: lanes, extension, splits,
// errors and reset during a split store.
module tb_data_mem;
  import data_mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0, v3 = 1'b0;
  logic         req_we = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [31:0]  req_wdata = 32'd0;
  memory_mask_t req_mask = MEM_WORD;
  logic         req_unsigned = 1'b0;
  logic         rdy0, rv0, er0, rdy3, rv3, er3;
  logic [31:0]  rd0, rd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_unsigned(req_unsigned), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
  );

  data_mem #(.DEPTH(1024), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_unsigned(req_unsigned), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on unit sel (0: u0, 1: u3); samples #1 after edges 0..15 following accept.
  task automatic req(input string tag, input bit sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input memory_mask_t mask, input logic uns,
                     input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int          lat = 0;
    int          guard = 0;
    logic [31:0] rdata = 32'd0;
    logic        err = 1'b0;
    logic [15:0] rv_bits = '0;
    logic [15:0] rdy_bits = '0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_mask = mask; req_unsigned = uns;
    v0 = !sel; v3 = sel;
    while (!(sel ? rdy3 : rdy0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0;
    rv_bits[0]  = sel ? rv3 : rv0;
    rdy_bits[0] = sel ? rdy3 : rdy0;
    for (int e = 1; e < 16; e++) begin
      @(posedge clk); #1;
      rv_bits[e]  = sel ? rv3 : rv0;
      rdy_bits[e] = sel ? rdy3 : rdy0;
      if (rv_bits[e] && lat == 0) begin
        lat   = e;
        rdata = sel ? rd3 : rd0;
        err   = sel ? er3 : er0;
      end
    end
    chk($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_rdata", tag), rdata, exp_rdata);
    chk($sformatf("%s_err", tag), {31'd0, err}, {31'd0, exp_err});
    chk($sformatf("%s_pulse", tag), {16'd0, rv_bits}, {16'd0, 16'd1 << exp_lat});
    chk($sformatf("%s_ready", tag), {16'd0, rdy_bits}, {16'd0, 16'hFFFF << (exp_lat + 1)});
    $display("%s: addr=%h we=%0d lat=%0d rdata=%h err=%0d", tag, addr, we, lat, rdata, err);
  endtask

  initial begin
    logic seen;
    // Reset, with a request offered that must be ignored.
    rst = 1'b1; v0 = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, rdy0}, 32'd0);
    chk("rst_ready3", {31'd0, rdy3}, 32'd0);
    chk("rst_valid", {31'd0, rv0}, 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_err", {31'd0, er0}, 32'd0);
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, rdy0}, 32'd1);
    chk("post_rst_valid", {31'd0, rv0}, 32'd0);

    // Aligned word and byte lanes.
    req("st_w10", 0, 1, 32'h10, 32'hDEADBEEF, MEM_WORD, 0, 1, 32'h0, 0);
    req("ld_w10", 0, 0, 32'h10, 32'h0, MEM_WORD, 0, 1, 32'hDEADBEEF, 0);
    req("st_b12", 0, 1, 32'h12, 32'h0000005A, MEM_BYTE, 0, 1, 32'h0, 0);
    req("ld_w10b", 0, 0, 32'h10, 32'h0, MEM_WORD, 1, 1, 32'hDE5ABEEF, 0);
    req("ld_b13s", 0, 0, 32'h13, 32'h0, MEM_BYTE, 0, 1, 32'hFFFFFFDE, 0);
    req("ld_b13u", 0, 0, 32'h13, 32'h0, MEM_BYTE, 1, 1, 32'h000000DE, 0);

    // Split word store and loads across the 0x0C/0x10 boundary.
    req("st_w0c", 0, 1, 32'h0C, 32'hAABBCCDD, MEM_WORD, 0, 1, 32'h0, 0);
    req("st_w0e", 0, 1, 32'h0E, 32'h11223344, MEM_WORD, 0, 2, 32'h0, 0);
    req("ld_w0c", 0, 0, 32'h0C, 32'h0, MEM_WORD, 0, 1, 32'h3344CCDD, 0);
    req("ld_w10c", 0, 0, 32'h10, 32'h0, MEM_WORD, 0, 1, 32'hDE5A1122, 0);
    req("ld_w0e", 0, 0, 32'h0E, 32'h0, MEM_WORD, 0, 2, 32'h11223344, 0);
    req("st_b0f", 0, 1, 32'h0F, 32'h00000080, MEM_BYTE, 0, 1, 32'h0, 0);
    req("st_b10", 0, 1, 32'h10, 32'h00000000, MEM_BYTE, 0, 1, 32'h0, 0);
    req("ld_h0fs", 0, 0, 32'h0F, 32'h0, MEM_HALFWORD, 0, 2, 32'h00000080, 0);
    req("ld_h0es", 0, 0, 32'h0E, 32'h0, MEM_HALFWORD, 0, 1, 32'hFFFF8044, 0);
    req("ld_h0eu", 0, 0, 32'h0E, 32'h0, MEM_HALFWORD, 1, 1, 32'h00008044, 0);

    // Errors: out of range, split past the top word, illegal mask.
    req("ld_oob", 0, 0, 32'h1000, 32'h0, MEM_WORD, 0, 1, 32'h0, 1);
    req("st_wffc", 0, 1, 32'hFFC, 32'h01020304, MEM_WORD, 0, 1, 32'h0, 0);
    req("st_hfff", 0, 1, 32'hFFF, 32'h0000BEEF, MEM_HALFWORD, 0, 1, 32'h0, 1);
    req("ld_wffc", 0, 0, 32'hFFC, 32'h0, MEM_WORD, 0, 1, 32'h01020304, 0);
    req("ld_badm", 0, 0, 32'h10, 32'h0, memory_mask_t'(2'b11), 0, 1, 32'h0, 1);

    // Reset during ACC_HI of a split store.
    req("st_w20", 0, 1, 32'h20, 32'h55555555, MEM_WORD, 0, 1, 32'h0, 0);
    req("st_w24", 0, 1, 32'h24, 32'h66666666, MEM_WORD, 0, 1, 32'h0, 0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h22; req_wdata = 32'hA1B2C3D4; req_mask = MEM_WORD;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    seen |= rv0;
    chk("midrst_ready", {31'd0, rdy0}, 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= rv0;
    end
    chk("midrst_no_resp", {31'd0, seen}, 32'd0);
    $display("midrst: resp seen=%0d", seen);
    req("ld_w20", 0, 0, 32'h20, 32'h0, MEM_WORD, 0, 1, 32'hC3D45555, 0);
    req("ld_w24", 0, 0, 32'h24, 32'h0, MEM_WORD, 0, 1, 32'h66666666, 0);

    // Three wait states.
    req("ws3_st40", 1, 1, 32'h40, 32'h12345678, MEM_WORD, 0, 4, 32'h0, 0);
    req("ws3_ld40", 1, 0, 32'h40, 32'h0, MEM_WORD, 0, 4, 32'h12345678, 0);
    req("ws3_st42", 1, 1, 32'h42, 32'hCAFEF00D, MEM_WORD, 0, 5, 32'h0, 0);
    req("ws3_ld42", 1, 0, 32'h42, 32'h0, MEM_WORD, 0, 5, 32'hCAFEF00D, 0);
    req("ws3_ld40b", 1, 0, 32'h40, 32'h0, MEM_WORD, 0, 4, 32'hF00D5678, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
